prog_counter: RTL
=================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 32, counter and cnt_init width in bits (range 2..64).
REQ-002 Parameter STEP, default 1, decrement per running cycle (1 <= STEP < 2**WIDTH).
REQ-003 Parameter PWIDTH, default 16, width of the completed-period counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cnt_init  input  WIDTH  load value, sampled only on an accepted start.
REQ-007 start  input  1  request to begin counting; accepted when start=1 and ready=1.
REQ-008 reload  input  1  mode select sampled with start: 0 one-shot, 1 auto-reload.
REQ-009 abort  input  1  terminate a running count.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle pulse marking each expiry.
REQ-012 cnt  output  WIDTH  current count value.
REQ-013 periods  output  PWIDTH  expiries since last accepted start, saturating.

Function
REQ-014 FSM SHALL have two states, IDLE and RUN; all outputs SHALL be registered or decoded only from registered state.
REQ-015 IDLE: ready=1, cnt holds its value, done=0; accepted start SHALL load cnt<=cnt_init, latch cnt_init and reload internally, clear periods, and enter RUN on the same edge.
REQ-016 RUN, cnt>0: next cnt SHALL be cnt-STEP, clamped to 0 when cnt<STEP (no wrap-around).
REQ-017 RUN, cnt==0: done SHALL be 1 in that cycle; periods SHALL increment on the following edge, saturating at all-ones.
REQ-018 RUN, cnt==0, latched reload=0: next state IDLE, cnt stays 0.
REQ-019 RUN, cnt==0, latched reload=1: cnt SHALL reload the latched init value and remain in RUN; live cnt_init changes SHALL have no effect.
REQ-020 Latency: with STEP=1, done SHALL assert exactly cnt_init+1 cycles after the edge that accepts start; ready returns the cycle after done in one-shot mode.
REQ-021 cnt_init=0 SHALL give done in the first RUN cycle; with reload=1, done SHALL then be high every cycle.
REQ-022 start while in RUN SHALL be ignored (no restart, no reload).
REQ-023 abort in RUN SHALL force IDLE on the next edge, cnt holding its present value, regardless of mode; a done already high in that cycle is not retracted, but periods SHALL still increment.
REQ-024 abort in IDLE SHALL be ignored; start and abort together in IDLE SHALL accept start.

Reset
REQ-025 rst=1 at any edge, including mid-RUN, SHALL force IDLE, cnt=0, periods=0, done=0, ready=1, and clear latched mode and init.
REQ-026 rst SHALL take priority over start, abort and pause.

Configuration
REQ-027 Macro PROG_COUNTER_PAUSE_EN defined: an input port pause (1 bit) SHALL exist; while pause=1 in RUN with cnt>0, cnt and state SHALL hold; the cnt==0 expiry and reload SHALL proceed regardless of pause.
REQ-028 Macro PROG_COUNTER_PAUSE_EN undefined: the pause port SHALL NOT exist, and behaviour SHALL equal the defined case with pause tied 0.

Verification
REQ-029 Reset 2 cycles, start with cnt_init=10, reload=0, STEP=1 -> cnt 10,9..0, done high for one cycle 11 cycles after start, ready=1 next cycle, periods=1.
REQ-030 cnt_init=4, reload=1, run 15 cycles -> done every 5 cycles, cnt sequence 4,3,2,1,0,4..., periods=3; cnt_init changed mid-run has no effect.
REQ-031 STEP=3, cnt_init=7 -> cnt 7,4,1,0, done once; no wrap to large values.
REQ-032 Start 10, abort when cnt=6 -> IDLE next cycle, cnt stays 6, no done; a second start issued during RUN is ignored.
REQ-033 rst asserted when cnt=5 in reload mode -> next cycle cnt=0, periods=0, ready=1, done=0.
REQ-034 With PROG_COUNTER_PAUSE_EN, start 5, pause for 3 cycles at cnt=3 -> cnt holds 3 for 3 cycles, done delayed by exactly 3 cycles.

Source files
------------

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable down-counter with one-shot/auto-reload modes and expiry count
// Optional pause input enabled by defining PROG_COUNTER_PAUSE_EN.
module prog_counter #(
  parameter int              WIDTH  = 32,
  parameter longint unsigned STEP   = 1,
  parameter int              PWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_init,
  input  logic              start,
  input  logic              reload,
  input  logic              abort,
`ifdef PROG_COUNTER_PAUSE_EN
  input  logic              pause,
`endif
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  cnt,
  output logic [PWIDTH-1:0] periods
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]  STEP_W = WIDTH'(STEP);
  localparam logic [PWIDTH-1:0] PMAX   = '1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    init_q, init_d;
  logic                rel_q, rel_d;
  logic [PWIDTH-1:0]   per_q, per_d;
  logic                expire;
  logic                pause_w;

`ifdef PROG_COUNTER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign expire = (state_q == RUN) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    rel_d   = rel_q;
    per_d   = per_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d   = cnt_init;
        init_d  = cnt_init;
        rel_d   = reload;
        per_d   = '0;
      end
    end else begin
      // An expiry is counted even when abort ends the run in the same cycle.
      if (expire && (per_q != PMAX)) per_d = per_q + PWIDTH'(1);
      if (abort) begin
        state_d = IDLE;
      end else if (expire) begin
        if (rel_q) cnt_d = init_q;
        else       state_d = IDLE;
      end else if (!pause_w) begin
        cnt_d = (cnt_q < STEP_W) ? '0 : cnt_q - STEP_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= '0;
      rel_q   <= 1'b0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      rel_q   <= rel_d;
      per_q   <= per_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = expire;
  assign cnt     = cnt_q;
  assign periods = per_q;

endmodule
